syn_r2w_status: RTL
===================

# syn_r2w_status

Parametrised successor to the basic read-to-write pointer synchroniser. Brings the Gray-coded read pointer into the write clock domain through a configurable-depth flop chain. From it, produces:
- a binary copy of the pointer,
- the write-side fill level, full and almost-full flags,
- a one-cycle read-advance pulse,
- a sticky Gray-coherence error flag.

Sits in the TX/RX FIFO write-side control. It replaces local full-flag arithmetic.

## Interface
Parameters:
- ASIZE, 4: FIFO address width. Pointers are ASIZE+1 bits (MSB = wrap bit); depth is 2**ASIZE.
- SYNC_STAGES, 2: synchroniser flop count. Legal range is 2..4; other values are a configuration error.
- AFULL_THRESH, 2**ASIZE-2: fill level at or above which walmost_full asserts. Legal range is 1..2**ASIZE.

Ports:
- wclk, in, 1: write-domain clock. One clock only.
- wrst_n, in, 1: reset, asynchronous assert, active-low.
- rptr, in, ASIZE+1: Gray-coded read pointer, asynchronous to wclk.
- wptr_bin_next, in, ASIZE+1: binary write pointer value that the write side will hold after this edge.
- err_clr, in, 1: synchronous clear for gray_err.
- s_rptr, out, ASIZE+1: synchronised Gray read pointer.
- s_rptr_bin, out, ASIZE+1: binary equivalent of s_rptr, registered.
- wfill, out, ASIZE+1: write-side occupancy, registered.
- wfull, out, 1: wfill == 2**ASIZE.
- walmost_full, out, 1: wfill >= AFULL_THRESH.
- rptr_adv, out, 1: one-cycle pulse when s_rptr_bin changes.
- gray_err, out, 1: sticky flag, set when two consecutive s_rptr samples differ in more than one bit.

## Operation
- Synchroniser: a chain of SYNC_STAGES registers, stage0 <= rptr, stage[i] <= stage[i-1]. s_rptr is the last stage. No logic is allowed between stages.
- Conversion: s_rptr_bin[ASIZE] = s_rptr[ASIZE]. For lower bits, s_rptr_bin[i] = s_rptr_bin[i+1] ^ s_rptr[i]. The result is registered.
- Fill: wfill <= (wptr_bin_next - s_rptr_bin) mod 2**(ASIZE+1). This is an unsigned subtraction truncated to ASIZE+1 bits, so wrap-around is handled by modular arithmetic.
- wfull and walmost_full are registered from the same computed fill value as wfill. They are never decoded from the wfill register.
- wfill is pessimistic: it can overstate occupancy by the synchroniser latency and never understates it. wfill above 2**ASIZE is illegal and the bench checks for it.
- rptr_adv: a previous-value register holds the last s_rptr_bin. The pulse goes high for one cycle when the two differ.
- gray_err: a previous-value register holds the last s_rptr. Set condition is popcount(s_rptr ^ prev) > 1.
  - Clears on err_clr.
  - If set and clear occur in the same cycle, set wins.
  - Once set, stays set until cleared or reset.
- Reset (wrst_n low): every register goes to 0 immediately, including the synchroniser stages and previous-value registers. All outputs read 0, so wfull=0 and walmost_full=0 (AFULL_THRESH >= 1).
- Reset mid-operation: the chain flushes to 0. After release, the block behaves as if rptr had just been applied. No spurious rptr_adv or gray_err is raised from the 0 baseline unless rptr genuinely differs.

## Timing
- rptr to s_rptr: SYNC_STAGES wclk edges.
- rptr to s_rptr_bin: SYNC_STAGES+1 edges.
- rptr to rptr_adv, wfill, wfull and walmost_full: SYNC_STAGES+2 edges.
- rptr to gray_err: SYNC_STAGES+1 edges.
- wptr_bin_next to wfill and flags: 1 edge. The flags are therefore aligned with the write pointer's registered value in the same cycle.
- Simultaneous write and read advance: each side's contribution appears at its own latency, with no arbitration needed.
- Reset release: the first capture of rptr happens on the first wclk rising edge with wrst_n high.

## Test plan
- Reset: drive rptr=5'b10110 and wptr_bin_next=7, assert wrst_n low mid-run -> every output is 0 immediately and stays 0 while held. After release with SYNC_STAGES=2, s_rptr=5'b10110 on the 2nd edge.
- Latency sweep: SYNC_STAGES=2, 3, 4 with a single rptr change 0 -> 1 (Gray). Required: s_rptr updates on edge 2/3/4, s_rptr_bin on 3/4/5, rptr_adv pulses for exactly one cycle on 4/5/6.
- Fill to full: ASIZE=4, rptr held at 0, wptr_bin_next stepped 0..16 -> wfill tracks 0..16 one edge later. walmost_full rises at wfill=14. wfull rises only at wfill=16.
- Wrap-around: wptr_bin_next=5'b00011 (3) and s_rptr_bin=5'b10111 (23) -> wfill=12, wfull=0, walmost_full=0. Then move wptr_bin_next to 7 -> wfill=16, wfull=1.
- Gray error: step rptr 0 -> 5'b00011 (two bits) -> gray_err=1 at SYNC_STAGES+1. It holds through further legal steps. Assert err_clr on a legal cycle -> gray_err=0 next edge. Assert err_clr in the same cycle as a new violation -> gray_err stays 1.
- Free-running: random legal Gray sequences on rptr with random wptr_bin_next increments against a reference model. Check:
  - wfill never exceeds 16;
  - wfill never understates the true occupancy;
  - gray_err stays 0.

Source files
------------

// File: rtl/syn_r2w_status.sv
// Brings the Gray read pointer into the write clock domain and derives the
// write-side fill level, full/almost-full flags, read-advance pulse and Gray error.
module syn_r2w_status #(
    parameter int ASIZE        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**ASIZE - 2
) (
    input  logic           wclk,
    input  logic           wrst_n,
    input  logic [ASIZE:0] rptr,
    input  logic [ASIZE:0] wptr_bin_next,
    input  logic           err_clr,
    output logic [ASIZE:0] s_rptr,
    output logic [ASIZE:0] s_rptr_bin,
    output logic [ASIZE:0] wfill,
    output logic           wfull,
    output logic           walmost_full,
    output logic           rptr_adv,
    output logic           gray_err
);

    localparam int PW = ASIZE + 1;
    localparam logic [PW-1:0] DEPTH_V  = PW'(2**ASIZE);
    localparam logic [PW-1:0] THRESH_V = PW'(AFULL_THRESH);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("syn_r2w_status: SYNC_STAGES must be in 2..4");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > 2**ASIZE) begin : g_bad_afull_thresh
            $error("syn_r2w_status: AFULL_THRESH must be in 1..2**ASIZE");
        end
    endgenerate

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_d [SYNC_STAGES];
    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] prev_bin_q, prev_bin_d;
    logic [PW-1:0] prev_gray_q, prev_gray_d;
    logic [PW-1:0] fill_q, fill_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          adv_q, adv_d;
    logic          err_q, err_d;
    logic          gray_bad;

    assign s_rptr = sync_q[SYNC_STAGES-1];

    // Plain flop chain: nothing may sit between stages.
    always_comb begin
        sync_d[0] = rptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        bin_d = '0;
        for (int i = 0; i < PW; i++) begin
            bin_d[i] = ^(s_rptr >> i);
        end
        prev_bin_d  = bin_q;
        prev_gray_d = s_rptr;
        // Modular subtraction handles pointer wrap without extra logic.
        fill_d      = wptr_bin_next - bin_q;
        full_d      = (fill_d == DEPTH_V);
        afull_d     = (fill_d >= THRESH_V);
        adv_d       = (bin_q != prev_bin_q);
        gray_bad    = ($countones(s_rptr ^ prev_gray_q) > 1);
        // A new violation takes priority over a simultaneous clear.
        err_d       = gray_bad | (err_q & ~err_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            bin_q       <= '0;
            prev_bin_q  <= '0;
            prev_gray_q <= '0;
            fill_q      <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            adv_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            bin_q       <= bin_d;
            prev_bin_q  <= prev_bin_d;
            prev_gray_q <= prev_gray_d;
            fill_q      <= fill_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            adv_q       <= adv_d;
            err_q       <= err_d;
        end
    end

    assign s_rptr_bin   = bin_q;
    assign wfill        = fill_q;
    assign wfull        = full_q;
    assign walmost_full = afull_q;
    assign rptr_adv     = adv_q;
    assign gray_err     = err_q;

endmodule
